// File: rtl/full_adder_unit_if.sv
// rtl/full_adder_unit_if.sv - operand/result bundle for the ripple-carry adder
interface full_adder_unit_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

  // Producer of operands, consumer of results
  modport master (
    output a, b, cin, in_valid,
    input  sum, cout, out_valid
  );

  // The adder itself
  modport slave (
    input  a, b, cin, in_valid,
    output sum, cout, out_valid
  );
endinterface

// File: rtl/full_adder_unit.sv
// rtl/full_adder_unit.sv - WIDTH-bit ripple-carry adder with optional output register
module full_adder_unit #(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  full_adder_unit_if.slave bus_if
);

  // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB cell
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign carry[0] = bus_if.cin;

  // One full-adder cell per bit; the carry ripples LSB to MSB
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic half_sum;
    assign half_sum     = bus_if.a[i] ^ bus_if.b[i];
    assign sum_d[i]     = half_sum ^ carry[i];
    assign carry[i + 1] = (bus_if.a[i] & bus_if.b[i]) | (carry[i] & half_sum);
  end

  assign cout_d = carry[WIDTH];

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             valid_q;

    // Capture the result only for qualified operands; valid tracks in_valid one cycle later
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q   <= '0;
        cout_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= bus_if.in_valid;
        if (bus_if.in_valid) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
        end
      end
    end

    assign bus_if.sum       = sum_q;
    assign bus_if.cout      = cout_q;
    assign bus_if.out_valid = valid_q;
  end else begin : g_comb
    // Purely combinational: clock, reset and the qualifier have no effect here
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, bus_if.in_valid};

    assign bus_if.sum       = sum_d;
    assign bus_if.cout      = cout_d;
    assign bus_if.out_valid = 1'b1;
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// tb/tb_full_adder_unit.sv - self-checking bench for full_adder_unit
module tb_full_adder_unit;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp;   // {cout, sum}
  } vec_t;

  full_adder_unit_if #(.WIDTH(1))  if_c1 ();
  full_adder_unit_if #(.WIDTH(8))  if_c8 ();
  full_adder_unit_if #(.WIDTH(8))  if_r8 ();
  full_adder_unit_if #(.WIDTH(16)) if_r16 ();

  full_adder_unit #(.WIDTH(1),  .OUT_REG(1'b0)) dut_c1  (.clk(clk), .rst(rst), .bus_if(if_c1));
  full_adder_unit #(.WIDTH(8),  .OUT_REG(1'b0)) dut_c8  (.clk(clk), .rst(rst), .bus_if(if_c8));
  full_adder_unit #(.WIDTH(8),  .OUT_REG(1'b1)) dut_r8  (.clk(clk), .rst(rst), .bus_if(if_r8));
  full_adder_unit #(.WIDTH(16), .OUT_REG(1'b1)) dut_r16 (.clk(clk), .rst(rst), .bus_if(if_r16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected state of the registered outputs
  logic [8:0]  m8;
  logic        mv8;
  logic [16:0] m16;
  logic        mv16;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_r8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    @(negedge clk);
    if_r8.a = a; if_r8.b = b; if_r8.cin = c; if_r8.in_valid = v;
    @(posedge clk);
    #1;
    if (v) m8 = {1'b0, a} + {1'b0, b} + {8'd0, c};
    mv8 = v;
    check("r8_result", {if_r8.cout, if_r8.sum}, m8);
    check("r8_valid", if_r8.out_valid, mv8);
  endtask

  task automatic apply_r16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic v);
    @(negedge clk);
    if_r16.a = a; if_r16.b = b; if_r16.cin = c; if_r16.in_valid = v;
    @(posedge clk);
    #1;
    if (v) m16 = {1'b0, a} + {1'b0, b} + {16'd0, c};
    mv16 = v;
    check("r16_result", {if_r16.cout, if_r16.sum}, m16);
    check("r16_valid", if_r16.out_valid, mv16);
  endtask

  initial begin
    vec_t t1[8];
    vec_t t8[4];
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] rexp;

    // Single-bit truth table, expected values written out by hand
    t1[0] = '{16'd0, 16'd0, 1'b0, 17'b00};
    t1[1] = '{16'd0, 16'd0, 1'b1, 17'b01};
    t1[2] = '{16'd0, 16'd1, 1'b0, 17'b01};
    t1[3] = '{16'd0, 16'd1, 1'b1, 17'b10};
    t1[4] = '{16'd1, 16'd0, 1'b0, 17'b01};
    t1[5] = '{16'd1, 16'd0, 1'b1, 17'b10};
    t1[6] = '{16'd1, 16'd1, 1'b0, 17'b10};
    t1[7] = '{16'd1, 16'd1, 1'b1, 17'b11};

    t8[0] = '{16'h00FF, 16'h0000, 1'b1, 17'h100};
    t8[1] = '{16'h005A, 16'h0033, 1'b0, 17'h08D};
    t8[2] = '{16'h00FF, 16'h00FF, 1'b1, 17'h1FF};
    t8[3] = '{16'h0000, 16'h0000, 1'b0, 17'h000};

    rst = 1'b0;
    m8 = '0; mv8 = 1'b0; m16 = '0; mv16 = 1'b0;
    if_c1.a = '0;  if_c1.b = '0;  if_c1.cin = 1'b0;  if_c1.in_valid = 1'b0;
    if_c8.a = '0;  if_c8.b = '0;  if_c8.cin = 1'b0;  if_c8.in_valid = 1'b0;
    if_r8.a = '0;  if_r8.b = '0;  if_r8.cin = 1'b0;  if_r8.in_valid = 1'b0;
    if_r16.a = '0; if_r16.b = '0; if_r16.cin = 1'b0; if_r16.in_valid = 1'b0;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_async_r8", {if_r8.out_valid, if_r8.cout, if_r8.sum}, 10'd0);
    check("rst_async_r16", {if_r16.out_valid, if_r16.cout, if_r16.sum}, 18'd0);

    // Reset holds across an edge even with a valid operand present
    if_r8.a = 8'hFF; if_r8.b = 8'hFF; if_r8.cin = 1'b1; if_r8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_r8", {if_r8.out_valid, if_r8.cout, if_r8.sum}, 10'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1-bit combinational sweep at 10-unit spacing
    for (int i = 0; i < 8; i++) begin
      if_c1.a = t1[i].a[0:0]; if_c1.b = t1[i].b[0:0]; if_c1.cin = t1[i].cin;
      #5;
      check($sformatf("c1_vec%0d", i), {if_c1.cout, if_c1.sum}, t1[i].exp);
      #5;
    end
    check("c1_valid_tied", if_c1.out_valid, 1'b1);

    // 8-bit combinational corner vectors
    for (int i = 0; i < 4; i++) begin
      if_c8.a = t8[i].a[7:0]; if_c8.b = t8[i].b[7:0]; if_c8.cin = t8[i].cin;
      #1;
      check($sformatf("c8_vec%0d", i), {if_c8.cout, if_c8.sum}, t8[i].exp);
    end
    check("c8_valid_tied", if_c8.out_valid, 1'b1);

    // First capture after reset release: all-ones + all-ones + 1
    apply_r8(8'hFF, 8'hFF, 1'b1, 1'b1);
    check("r8_first_capture", {if_r8.out_valid, if_r8.cout, if_r8.sum}, {1'b1, 1'b1, 8'hFF});

    // Back-to-back valid operands, one result per cycle
    apply_r8(8'h01, 8'h01, 1'b0, 1'b1);
    check("r8_b2b_0", {if_r8.cout, if_r8.sum}, 9'h002);
    apply_r8(8'h02, 8'h03, 1'b1, 1'b1);
    check("r8_b2b_1", {if_r8.cout, if_r8.sum}, 9'h006);
    apply_r8(8'h80, 8'h80, 1'b0, 1'b1);
    check("r8_b2b_2", {if_r8.cout, if_r8.sum}, 9'h100);

    // Unqualified operands: result holds, valid drops
    apply_r8(8'h12, 8'h34, 1'b1, 1'b0);
    apply_r8(8'hAB, 8'hCD, 1'b0, 1'b0);
    check("r8_hold", {if_r8.out_valid, if_r8.cout, if_r8.sum}, {1'b0, 9'h100});

    // Reset between two valid inputs discards the pending one
    apply_r8(8'h10, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    if_r8.a = 8'h44; if_r8.b = 8'h11; if_r8.cin = 1'b0; if_r8.in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    m8 = '0; mv8 = 1'b0; m16 = '0; mv16 = 1'b0;
    check("r8_midrst_clear", {if_r8.out_valid, if_r8.cout, if_r8.sum}, 10'd0);
    @(posedge clk);
    #1;
    check("r8_midrst_held", {if_r8.out_valid, if_r8.cout, if_r8.sum}, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    if_r8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("r8_pending_dropped", {if_r8.out_valid, if_r8.cout, if_r8.sum}, 10'd0);
    apply_r8(8'h44, 8'h11, 1'b0, 1'b1);
    check("r8_recover", {if_r8.cout, if_r8.sum}, 9'h055);

    // Random sweep, 8-bit combinational
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      if_c8.a = ra[7:0]; if_c8.b = rb[7:0]; if_c8.cin = rc;
      #1;
      rexp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      check("c8_rand", {if_c8.cout, if_c8.sum}, rexp);
    end

    // Random sweep, 16-bit registered with sporadic valid
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      apply_r16(ra, rb, rc, ($urandom_range(0, 3) != 0));
    end
    apply_r16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    check("r16_all_ones", {if_r16.cout, if_r16.sum}, 17'h1FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
